// File: rtl/dcache_pkg.sv
// Shared constants, FSM encoding and helpers for the dcache miss-side replacement path.
package dcache_pkg;

    localparam int IDX_W  = 6;
    localparam int TAG_W  = 20;
    localparam int WAYS   = 4;
    localparam int ADDR_W = TAG_W + IDX_W;

    localparam logic [WAYS-1:0] WAY_FALLBACK = {{(WAYS-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        VICTIM      = 4'd1,
        META_RD     = 4'd2,
        META_WAIT   = 4'd3,
        WB_REQ      = 4'd4,
        WB_WAIT     = 4'd5,
        REFILL_REQ  = 4'd6,
        REFILL_WAIT = 4'd7,
        META_WR     = 4'd8
    } state_t;

    function automatic logic is_onehot(input logic [WAYS-1:0] w);
        return (w != {WAYS{1'b0}}) &&
               ((w & (w - {{(WAYS-1){1'b0}}, 1'b1})) == {WAYS{1'b0}});
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                     input logic [IDX_W-1:0] set);
        return {tag, set};
    endfunction

endpackage

// File: rtl/dcache_replace_ctrl.sv
// Miss-side replacement controller: commits the PLRU victim, reads its metadata,
// writes back dirty victims, refills the line and rewrites the victim's tag.
module dcache_replace_ctrl
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                miss_valid,
    output logic                miss_ready,
    input  logic [IDX_W-1:0]    miss_set,
    input  logic [TAG_W-1:0]    miss_tag,
    output logic                plru_valid,
    output logic [IDX_W-1:0]    plru_set,
    input  logic [WAYS-1:0]     plru_way,
    output logic                meta_rd_en,
    output logic [IDX_W-1:0]    meta_rd_set,
    output logic [WAYS-1:0]     meta_rd_way,
    input  logic                meta_rd_vld,
    input  logic                meta_rd_dirty,
    input  logic [TAG_W-1:0]    meta_rd_tag,
    output logic                wb_req_valid,
    input  logic                wb_req_ready,
    output logic [ADDR_W-1:0]   wb_req_addr,
    output logic [WAYS-1:0]     wb_req_way,
    input  logic                wb_done,
    output logic                refill_req_valid,
    input  logic                refill_req_ready,
    output logic [ADDR_W-1:0]   refill_req_addr,
    output logic [WAYS-1:0]     refill_req_way,
    input  logic                refill_done,
    output logic                meta_wr_en,
    output logic [IDX_W-1:0]    meta_wr_set,
    output logic [WAYS-1:0]     meta_wr_way,
    output logic [TAG_W-1:0]    meta_wr_tag,
    output logic                busy,
    output logic                err_way
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_set;
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   r_vtag;
    logic [WAYS-1:0]    r_way;
    logic               r_miss_ready;
    logic               r_busy;
    logic               r_plru_valid;
    logic               r_meta_rd_en;
    logic               r_wb_valid;
    logic               r_rf_valid;
    logic               r_meta_wr_en;
    logic               r_err_way;

    // PLRU looks up its victim combinationally, so the set is only presented while committing.
    assign plru_set         = (r_state == VICTIM) ? r_set : {IDX_W{1'b0}};

    assign miss_ready       = r_miss_ready;
    assign busy             = r_busy;
    assign plru_valid       = r_plru_valid;
    assign meta_rd_en       = r_meta_rd_en;
    assign meta_rd_set      = r_set;
    assign meta_rd_way      = r_way;
    assign wb_req_valid     = r_wb_valid;
    assign wb_req_addr      = line_addr(r_vtag, r_set);
    assign wb_req_way       = r_way;
    assign refill_req_valid = r_rf_valid;
    assign refill_req_addr  = line_addr(r_tag, r_set);
    assign refill_req_way   = r_way;
    assign meta_wr_en       = r_meta_wr_en;
    assign meta_wr_set      = r_set;
    assign meta_wr_way      = r_way;
    assign meta_wr_tag      = r_tag;
    assign err_way          = r_err_way;

    // Miss sequencing FSM; every strobe is produced one edge ahead of the cycle it is seen in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_set        <= {IDX_W{1'b0}};
            r_tag        <= {TAG_W{1'b0}};
            r_vtag       <= {TAG_W{1'b0}};
            r_way        <= {WAYS{1'b0}};
            r_miss_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_plru_valid <= 1'b0;
            r_meta_rd_en <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_rf_valid   <= 1'b0;
            r_meta_wr_en <= 1'b0;
            r_err_way    <= 1'b0;
        end else begin
            r_plru_valid <= 1'b0;
            r_meta_rd_en <= 1'b0;
            r_meta_wr_en <= 1'b0;
            r_err_way    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (miss_valid && r_miss_ready) begin
                        r_set        <= miss_set;
                        r_tag        <= miss_tag;
                        r_plru_valid <= 1'b1;
                        r_miss_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= VICTIM;
                    end
                end
                VICTIM: begin
                    // A corrupt PLRU choice still needs a usable way; fall back to way 0 and flag it.
                    if (is_onehot(plru_way)) begin
                        r_way <= plru_way;
                    end else begin
                        r_way     <= WAY_FALLBACK;
                        r_err_way <= 1'b1;
                    end
                    r_meta_rd_en <= 1'b1;
                    r_state      <= META_RD;
                end
                META_RD: begin
                    r_state <= META_WAIT;
                end
                META_WAIT: begin
                    r_vtag <= meta_rd_tag;
                    if (meta_rd_vld && meta_rd_dirty) begin
                        r_wb_valid <= 1'b1;
                        r_state    <= WB_REQ;
                    end else begin
                        r_rf_valid <= 1'b1;
                        r_state    <= REFILL_REQ;
                    end
                end
                WB_REQ: begin
                    if (wb_req_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (wb_done) begin
                        r_rf_valid <= 1'b1;
                        r_state    <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (refill_req_ready) begin
                        r_rf_valid <= 1'b0;
                        r_state    <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (refill_done) begin
                        r_meta_wr_en <= 1'b1;
                        r_state      <= META_WR;
                    end
                end
                META_WR: begin
                    r_miss_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_wb_valid   <= 1'b0;
                    r_rf_valid   <= 1'b0;
                    r_miss_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_replace_ctrl.sv
// Self-checking bench for dcache_replace_ctrl: directed vector table, reset-abort
// sequence and randomized misses checked against a transaction-level model.
module tb_dcache_replace_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        miss_valid, miss_ready;
    logic [5:0]  miss_set;
    logic [19:0] miss_tag;
    logic        plru_valid;
    logic [5:0]  plru_set;
    logic [3:0]  plru_way;
    logic        meta_rd_en;
    logic [5:0]  meta_rd_set;
    logic [3:0]  meta_rd_way;
    logic        meta_rd_vld, meta_rd_dirty;
    logic [19:0] meta_rd_tag;
    logic        wb_req_valid, wb_req_ready;
    logic [25:0] wb_req_addr;
    logic [3:0]  wb_req_way;
    logic        wb_done;
    logic        refill_req_valid, refill_req_ready;
    logic [25:0] refill_req_addr;
    logic [3:0]  refill_req_way;
    logic        refill_done;
    logic        meta_wr_en;
    logic [5:0]  meta_wr_set;
    logic [3:0]  meta_wr_way;
    logic [19:0] meta_wr_tag;
    logic        busy, err_way;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  set;
        logic [19:0] tag;
        logic [3:0]  plru;
        logic        vld;
        logic        dirty;
        logic [19:0] vtag;
        int          wbw;
        int          rfw;
        logic        stray;
        logic [3:0]  exp_way;
        logic        exp_err;
        logic        exp_wb;
    } vec_t;

    vec_t tbl[6];
    vec_t rv;

    logic [5:0] cur_set;
    logic [3:0] cur_plru;

    // PLRU stand-in: answers the victim only for the set of the current miss.
    assign plru_way = (plru_set == cur_set) ? cur_plru : ~cur_plru;

    dcache_replace_ctrl dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_set(miss_set), .miss_tag(miss_tag),
        .plru_valid(plru_valid), .plru_set(plru_set), .plru_way(plru_way),
        .meta_rd_en(meta_rd_en), .meta_rd_set(meta_rd_set), .meta_rd_way(meta_rd_way),
        .meta_rd_vld(meta_rd_vld), .meta_rd_dirty(meta_rd_dirty), .meta_rd_tag(meta_rd_tag),
        .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
        .wb_req_addr(wb_req_addr), .wb_req_way(wb_req_way), .wb_done(wb_done),
        .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
        .refill_req_addr(refill_req_addr), .refill_req_way(refill_req_way),
        .refill_done(refill_done),
        .meta_wr_en(meta_wr_en), .meta_wr_set(meta_wr_set),
        .meta_wr_way(meta_wr_way), .meta_wr_tag(meta_wr_tag),
        .busy(busy), .err_way(err_way)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what a miss must produce, from the replacement rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        o.exp_err = ($countones(v.plru) != 1);
        o.exp_way = o.exp_err ? 4'b0001 : v.plru;
        o.exp_wb  = v.vld && v.dirty;
        return o;
    endfunction

    task automatic run_miss(input vec_t v, input logic abort);
        int c = 0, guard = 0;
        int n_plru = 0, n_err = 0, n_rd = 0, n_wr = 0;
        int wb_first = -1, rf_first = -1, wr_cyc = -1;
        int wb_cnt = 0, rf_cnt = 0, wb_dcnt = 0, rf_dcnt = 0;
        int wbdone_cyc = -1, rfdone_cyc = -1;
        logic rd_pend = 1'b0, abort_pend = 1'b0, done = 1'b0, quiet = 1'b1;
        logic bad_plru = 1'b0, bad_rd = 1'b0, bad_wb = 1'b0, bad_rf = 1'b0, bad_wr = 1'b0;
        logic overlap = 1'b0, rf_early = 1'b0;

        cur_set  = v.set;
        cur_plru = v.plru;
        while (!miss_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_miss", miss_ready, 1'b1);
        if (v.stray) begin
            wb_done = 1'b1; refill_done = 1'b1;
            @(negedge clk);
            wb_done = 1'b0; refill_done = 1'b0;
            @(negedge clk);
            chk("stray_done_idle", {miss_ready, busy, refill_req_valid, wb_req_valid, meta_wr_en}, 5'b10000);
        end
        miss_valid = 1'b1;
        miss_set   = v.set;
        miss_tag   = v.tag;
        @(posedge clk);

        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            miss_valid = 1'b0;
            if (abort_pend) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_idle", {plru_valid, meta_rd_en, wb_req_valid, refill_req_valid,
                                   meta_wr_en, busy, err_way, miss_ready}, 8'b0000_0001);
                chk("abort_cleared", {meta_rd_set, meta_rd_way, meta_wr_tag, refill_req_way}, 34'd0);
                for (int k = 0; k < 8; k++) begin
                    wb_done     = (k == 1);
                    refill_done = (k == 3);
                    @(negedge clk);
                    if (meta_wr_en || refill_req_valid || wb_req_valid || busy) quiet = 1'b0;
                end
                wb_done = 1'b0; refill_done = 1'b0;
                chk("abort_quiet", quiet, 1'b1);
                done = 1'b1;
            end else begin
                if (c == 1) chk("busy_after_accept", {busy, miss_ready}, 2'b10);
                if (wr_cyc >= 0 && c == wr_cyc + 1) begin
                    chk("ready_after_meta_wr", {miss_ready, busy}, 2'b10);
                    done = 1'b1;
                end
                // Metadata RAM: data is valid only in the cycle after the read strobe.
                if (rd_pend) begin
                    meta_rd_vld = v.vld; meta_rd_dirty = v.dirty; meta_rd_tag = v.vtag;
                    rd_pend = 1'b0;
                end else begin
                    meta_rd_vld = ~v.vld; meta_rd_dirty = ~v.dirty; meta_rd_tag = ~v.vtag;
                end
                if (plru_valid) begin
                    n_plru++;
                    if (plru_set !== v.set) bad_plru = 1'b1;
                end
                if (err_way) n_err++;
                if (meta_rd_en) begin
                    n_rd++;
                    rd_pend = 1'b1;
                    if ({meta_rd_set, meta_rd_way} !== {v.set, v.exp_way}) bad_rd = 1'b1;
                end
                if (wb_req_valid && refill_req_valid) overlap = 1'b1;
                wb_done = (wb_dcnt == 1);
                if (wb_dcnt == 1) wbdone_cyc = c;
                if (wb_dcnt > 0) wb_dcnt--;
                refill_done = (rf_dcnt == 1);
                if (rf_dcnt == 1) rfdone_cyc = c;
                if (rf_dcnt > 0) rf_dcnt--;
                wb_req_ready = 1'b0;
                refill_req_ready = 1'b0;
                if (wb_req_valid) begin
                    if (wb_first < 0) wb_first = c;
                    if ({wb_req_addr, wb_req_way} !== {v.vtag, v.set, v.exp_way}) bad_wb = 1'b1;
                    if (wb_cnt >= v.wbw) begin
                        wb_req_ready = 1'b1;
                        wb_dcnt = 3;
                        if (abort) abort_pend = 1'b1;
                    end
                    wb_cnt++;
                end
                if (refill_req_valid) begin
                    if (rf_first < 0) rf_first = c;
                    if ({refill_req_addr, refill_req_way} !== {v.tag, v.set, v.exp_way}) bad_rf = 1'b1;
                    if (v.vld && v.dirty && wbdone_cyc < 0) rf_early = 1'b1;
                    if (rf_cnt >= v.rfw) begin
                        refill_req_ready = 1'b1;
                        rf_dcnt = 3;
                    end else if (v.stray) begin
                        wb_done = 1'b1;
                        refill_done = 1'b1;
                    end
                    rf_cnt++;
                end
                if (meta_wr_en) begin
                    n_wr++;
                    wr_cyc = c;
                    if ({meta_wr_set, meta_wr_way, meta_wr_tag} !== {v.set, v.exp_way, v.tag}) bad_wr = 1'b1;
                end
            end
        end
        wb_done = 1'b0; refill_done = 1'b0; wb_req_ready = 1'b0; refill_req_ready = 1'b0;
        chk("miss_completes", done, 1'b1);
        if (!abort) begin
            chk("plru_pulses", n_plru, 1);
            chk("plru_set", bad_plru, 1'b0);
            chk("err_way_pulses", n_err, v.exp_err);
            chk("meta_rd_pulses", n_rd, 1);
            chk("meta_rd_payload", bad_rd, 1'b0);
            chk("wb_issued", wb_first >= 0, v.exp_wb);
            chk("wb_valid_cycles", wb_cnt, v.exp_wb ? v.wbw + 1 : 0);
            chk("wb_payload", bad_wb, 1'b0);
            if (v.exp_wb) chk("wb_first_cycle", wb_first, 4);
            chk("refill_first_cycle", rf_first, v.exp_wb ? wbdone_cyc + 1 : 4);
            chk("refill_valid_cycles", rf_cnt, v.rfw + 1);
            chk("refill_payload", bad_rf, 1'b0);
            chk("refill_before_wb_done", rf_early, 1'b0);
            chk("wb_refill_overlap", overlap, 1'b0);
            chk("meta_wr_pulses", n_wr, 1);
            chk("meta_wr_cycle", wr_cyc, rfdone_cyc + 1);
            chk("meta_wr_payload", bad_wr, 1'b0);
        end
    endtask

    initial begin
        //          set    tag        plru     vld   dirty vtag      wbw rfw stray  way      err   wb
        tbl[0] = '{6'd5,  20'h01234, 4'b0100, 1'b0, 1'b0, 20'h00000, 0, 0, 1'b0, 4'b0100, 1'b0, 1'b0};
        tbl[1] = '{6'd63, 20'h00042, 4'b1000, 1'b1, 1'b1, 20'hABCDE, 3, 1, 1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[2] = '{6'd10, 20'h00007, 4'b0010, 1'b1, 1'b0, 20'h55555, 0, 0, 1'b0, 4'b0010, 1'b0, 1'b0};
        tbl[3] = '{6'd20, 20'hFFFFF, 4'b0000, 1'b0, 1'b1, 20'h12345, 0, 1, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[4] = '{6'd0,  20'h00011, 4'b0001, 1'b0, 1'b0, 20'h00000, 0, 2, 1'b1, 4'b0001, 1'b0, 1'b0};
        tbl[5] = '{6'd0,  20'h00022, 4'b0011, 1'b1, 1'b1, 20'h00003, 0, 0, 1'b0, 4'b0001, 1'b1, 1'b1};

        reset = 1'b1;
        miss_valid = 1'b0; miss_set = 6'd0; miss_tag = 20'd0;
        meta_rd_vld = 1'b0; meta_rd_dirty = 1'b0; meta_rd_tag = 20'd0;
        wb_req_ready = 1'b0; wb_done = 1'b0; refill_req_ready = 1'b0; refill_done = 1'b0;
        cur_set = 6'd0; cur_plru = 4'b0001;
        repeat (3) @(negedge clk);
        chk("reset_idle", {plru_valid, meta_rd_en, wb_req_valid, refill_req_valid,
                           meta_wr_en, busy, err_way, miss_ready}, 8'b0000_0001);
        chk("reset_cleared", {meta_rd_set, meta_rd_way, meta_wr_tag, refill_req_way}, 34'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_miss(tbl[i], 1'b0);

        rv = model('{6'd33, 20'h0BEEF, 4'b0010, 1'b1, 1'b1, 20'h7777A, 1, 0, 1'b0, 4'b0000, 1'b0, 1'b0});
        run_miss(rv, 1'b1);
        run_miss(tbl[0], 1'b0);

        for (int i = 0; i < 40; i++) begin
            rv.set   = 6'($urandom_range(0, 63));
            rv.tag   = 20'($urandom);
            rv.plru  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            rv.vld   = 1'($urandom);
            rv.dirty = 1'($urandom);
            rv.vtag  = 20'($urandom);
            rv.wbw   = int'($urandom_range(0, 3));
            rv.rfw   = int'($urandom_range(0, 3));
            rv.stray = 1'($urandom);
            run_miss(model(rv), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_replace_ctrl.md
Name: dcache_replace_ctrl

Overview:
- Miss-side replacement controller for the 4-way, 64-set non-blocking dcache.
- Sits directly downstream of the PLRU victim selector. On a miss it:
  - commits the PLRU victim choice for the set (PLRU state updates on the same edge);
  - reads the victim's metadata;
  - issues a writeback if the victim is valid and dirty;
  - requests the refill and rewrites the victim's metadata with the new tag.
- Handles one miss at a time.

Parameters:
- IDX_W, 6, set index width (64 sets)
- WAYS, 4, associativity; way selects are one-hot
- TAG_W, 20, tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- miss_valid  in  1  miss request
- miss_ready  out  1  controller idle and can accept a miss
- miss_set  in  IDX_W  set of the missing line
- miss_tag  in  TAG_W  tag of the missing line
- plru_valid  out  1  one-cycle commit strobe to PLRU; hit input is tied 0
- plru_set  out  IDX_W  set presented to PLRU
- plru_way  in  WAYS  PLRU victim, one-hot, combinational from plru_set
- meta_rd_en  out  1  metadata read strobe
- meta_rd_set  out  IDX_W  metadata read set
- meta_rd_way  out  WAYS  metadata read way
- meta_rd_vld  in  1  victim valid bit, returned 1 cycle after meta_rd_en
- meta_rd_dirty  in  1  victim dirty bit, same timing
- meta_rd_tag  in  TAG_W  victim tag, same timing
- wb_req_valid  out  1  writeback request
- wb_req_ready  in  1  writeback request accepted
- wb_req_addr  out  TAG_W+IDX_W  victim line address {tag,set}
- wb_req_way  out  WAYS  victim way
- wb_done  in  1  writeback data drained
- refill_req_valid  out  1  refill request
- refill_req_ready  in  1  refill request accepted
- refill_req_addr  out  TAG_W+IDX_W  missing line address {miss_tag,miss_set}
- refill_req_way  out  WAYS  destination way
- refill_done  in  1  refill data written
- meta_wr_en  out  1  one-cycle metadata write
- meta_wr_set  out  IDX_W  metadata write set
- meta_wr_way  out  WAYS  metadata write way
- meta_wr_tag  out  TAG_W  metadata write tag; valid=1, dirty=0 are implied
- busy  out  1  state != IDLE
- err_way  out  1  one-cycle pulse when plru_way was not one-hot

Behaviour:
- Reset:
  - state=IDLE; every valid/strobe/err output 0; miss_ready=1; busy=0.
  - Latched set, tag and way registers cleared to 0.
  - Reset mid-operation abandons the miss: no metadata write is issued, and the PLRU update already committed is kept.
- IDLE:
  - miss_ready=1.
  - On miss_valid&miss_ready: latch set and tag, go to VICTIM.
- VICTIM (exactly 1 cycle):
  - plru_valid=1, plru_set=latched set.
  - Latch plru_way at the clock edge.
  - If plru_way is not one-hot, latch 4'b0001 instead and pulse err_way.
  - Go to META_RD.
- META_RD (1 cycle):
  - meta_rd_en=1 with latched set and way.
  - Go to META_WAIT.
- META_WAIT (1 cycle):
  - Sample meta_rd_vld, meta_rd_dirty and meta_rd_tag.
  - If vld&dirty, go to WB_REQ; otherwise go to REFILL_REQ.
- WB_REQ:
  - wb_req_valid=1 with addr={victim tag, set} and way.
  - Payload is held stable until wb_req_ready; valid never drops before the handshake.
  - On handshake, go to WB_WAIT.
- WB_WAIT:
  - Wait for wb_done, then go to REFILL_REQ.
  - wb_done in any other state is ignored.
- REFILL_REQ:
  - Same hold rules as WB_REQ.
  - On handshake, go to REFILL_WAIT.
- REFILL_WAIT:
  - Wait for refill_done, then go to META_WR.
  - refill_done in any other state is ignored.
- META_WR (1 cycle):
  - meta_wr_en=1 with set, way and miss_tag.
  - Go to IDLE. miss_ready is back at 1 in the following cycle; back-to-back misses add no bubble beyond this.
- Clean-miss latency:
  - Accept at edge 0; refill_req_valid is first high in cycle 4.
  - A ready=1 handshake is at edge 4 (same for wb_req when zero-wait).
- Dirty-miss path: the writeback request precedes the refill request; the two are never asserted together.
- Invalid victim: no writeback, regardless of dirty.
- Outputs are registered except plru_set, which is state-decoded.

Decomposition:
- Package dcache_pkg:
  - IDX_W, TAG_W, WAYS constants;
  - state enum (IDLE, VICTIM, META_RD, META_WAIT, WB_REQ, WB_WAIT, REFILL_REQ, REFILL_WAIT, META_WR);
  - is_onehot function;
  - line-address concat helper.
- Single module; no sub-module is needed.

Test Plan:
1. Clean miss: set=5, tag=0x1234; PLRU returns 0100; meta vld=0 -> no wb_req; refill_req_valid in cycle 4 with addr={0x1234,5} and way 0100; after refill_done, meta_wr_en with set 5, way 0100, tag 0x1234.
2. Dirty victim: set=63; meta vld=1, dirty=1, tag=0xABCDE; wb_req_ready held 0 for 3 cycles -> wb_req_valid and addr={0xABCDE,63} stable throughout; no refill_req until wb_done.
3. Valid but clean victim: vld=1, dirty=0 -> goes directly to refill, no wb_req_valid ever.
4. PLRU returns 0000 -> err_way pulses once; way 0001 is used for read, refill and metadata write.
5. Reset asserted in WB_WAIT -> next cycle all outputs idle, miss_ready=1, no meta_wr_en; a new miss is then processed normally.
6. Stray wb_done/refill_done pulses in IDLE and in REFILL_REQ are ignored; two back-to-back misses to set 0 each produce exactly one plru_valid pulse.
